// File: rtl/fir_out_decim.sv
// FIR output stage: drops pipeline warm-up samples, decimates by accumulate-and-dump,
// rounds/shifts/saturates each result and queues it in a first-word-fall-through FIFO.
module fir_out_decim #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned SKIP       = 18,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   data_in,
  input  logic                          en,
  output logic [15:0]                   dec_out,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned PH_W   = $clog2(DECIM);
  localparam int unsigned ACC_W  = 16 + PH_W;
  localparam int unsigned SUM_W  = ACC_W + 2;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned SK_W   = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int unsigned RND_I  = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

  localparam logic [SUM_W-1:0] RND       = SUM_W'(RND_I);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DECIM - 1);
  localparam logic [SK_W-1:0]  SKIP_LAST = SK_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {StWarmup, StAccum} state_e;

  localparam state_e ST_RESET = (SKIP == 0) ? StAccum : StWarmup;

  state_e             r_state, w_state_d;
  logic [SK_W-1:0]    r_skip_cnt;
  logic [PH_W-1:0]    r_phase;
  logic [ACC_W-1:0]   r_acc;
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;

  logic [SUM_W-1:0]   w_sum, w_res;
  logic [15:0]        w_result;
  logic               w_push, w_pop, w_full, w_wr;

  always_comb begin
    w_state_d = r_state;
    if (en && r_state == StWarmup && r_skip_cnt == SKIP_LAST) begin
      w_state_d = StAccum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RESET;
      r_skip_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (en && r_state == StWarmup) begin
        r_skip_cnt <= r_skip_cnt + SK_W'(1);
      end
    end
  end

  // Sum carries two spare bits so rounding can never wrap before saturation.
  assign w_sum    = SUM_W'(r_acc) + SUM_W'(data_in) + RND;
  assign w_res    = w_sum >> SHIFT;
  assign w_result = (|w_res[SUM_W-1:16]) ? 16'hFFFF : w_res[15:0];
  assign w_push   = en && (r_state == StAccum) && (r_phase == PH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_acc   <= '0;
    end else if (en && r_state == StAccum) begin
      if (r_phase == PH_LAST) begin
        r_phase <= '0;
        r_acc   <= '0;
      end else begin
        r_phase <= r_phase + PH_W'(1);
        r_acc   <= r_acc + ACC_W'(data_in);
      end
    end
  end

  assign dec_valid  = (r_level != '0);
  assign w_pop      = dec_valid && dec_ready;
  assign w_full     = (r_level == LVL_FULL);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr       = w_push && (!w_full || w_pop);
  assign dec_out    = dec_valid ? r_mem[r_rptr] : 16'h0000;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_wr && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_wr && w_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
